// File: rtl/rs_pkg.sv
// Shared widths, field constants and the search-state encoding for the
// Reed-Solomon Chien root search.
package rs_pkg;
  localparam int GF_W           = 8;
  localparam int FIELD_N        = 255;
  localparam int MAX_ERRORS_DEF = 16;
  localparam int RED_W          = 57;

  typedef enum logic [1:0] {
    CAPTURE,
    POWERS,
    SEARCH,
    DONE
  } state_t;
endpackage

// File: rtl/rs_chien_root_search_gf_mul8.sv
// Combinational GF(2^8) multiplier. The field polynomial is supplied as a reduction
// matrix. Column i holds x^(8+i) mod P(x), with bit j of that column at reduction_matrix[7*j+i].
module gf_mul8
  import rs_pkg::*;
(
  input  logic [GF_W-1:0]  a,
  input  logic [GF_W-1:0]  b,
  input  logic [RED_W-1:0] reduction_matrix,
  output logic [GF_W-1:0]  p
);
  logic [2*GF_W-2:0] c;
  logic [GF_W-1:0]   col [GF_W-1];
  logic              unused_msb;

  assign unused_msb = reduction_matrix[RED_W-1];

  for (genvar gi = 0; gi < GF_W-1; gi++) begin : g_col
    for (genvar gj = 0; gj < GF_W; gj++) begin : g_bit
      assign col[gi][gj] = reduction_matrix[(GF_W-1)*gj + gi];
    end
  end

  // Carry-less product first, then fold each overflow bit back through its matrix column.
  always_comb begin
    c = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) c = c ^ ({{(GF_W-1){1'b0}}, a} << i);
    end
    p = c[GF_W-1:0];
    for (int i = 0; i < GF_W-1; i++) begin
      if (c[GF_W+i]) p = p ^ col[i];
    end
  end
endmodule

// File: rtl/rs_chien_root_search.sv
// Chien search: evaluates Lambda(g^k) for k=0..254 and records up to MAX_ERRORS roots in ascending-k order.
// The optional RS_ROOT_COUNT_EN macro adds a num_roots output that reports how many roots were stored.
module rs_chien_root_search
  import rs_pkg::*;
#(
  parameter int MAX_ERRORS = MAX_ERRORS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [GF_W-1:0]            generator,
  input  logic [GF_W*MAX_ERRORS-1:0] error_locator,
  input  logic [RED_W-1:0]           reduction_matrix,
`ifdef RS_ROOT_COUNT_EN
  output logic [4:0]                 num_roots,
`endif
  output logic                       done,
  output logic [GF_W*MAX_ERRORS-1:0] roots
);
  localparam logic [4:0] M_CNT  = 5'(MAX_ERRORS);
  localparam logic [7:0] K_LAST = 8'(FIELD_N - 1);

  state_t            state_reg, state_next;
  logic [GF_W-1:0]   g_r, cur_reg, pow_last_reg, cur_p, pow_p, sum;
  logic [RED_W-1:0]  red_r;
  logic [4:0]        pidx_reg, count_reg;
  logic [7:0]        k_reg;
  logic              done_reg, store_root;
  logic [GF_W-1:0]   term_all [MAX_ERRORS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= CAPTURE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CAPTURE: state_next = POWERS;
      POWERS:  if (pidx_reg == M_CNT) state_next = SEARCH;
      SEARCH:  if (k_reg == K_LAST) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = CAPTURE;
    endcase
  end

  // Lambda_0 is the implicit constant 1.
  always_comb begin
    sum = 8'h01;
    for (int n = 0; n < MAX_ERRORS; n++) sum = sum ^ term_all[n];
  end

  assign store_root = (state_reg == SEARCH) && (sum == '0) && (count_reg < M_CNT);

  gf_mul8 u_pow_mul (.a(pow_last_reg), .b(g_r), .reduction_matrix(red_r), .p(pow_p));
  gf_mul8 u_cur_mul (.a(cur_reg),      .b(g_r), .reduction_matrix(red_r), .p(cur_p));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_r          <= '0;
      red_r        <= '0;
      cur_reg      <= '0;
      pow_last_reg <= '0;
      pidx_reg     <= '0;
      k_reg        <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        CAPTURE: begin
          g_r          <= generator;
          red_r        <= reduction_matrix;
          cur_reg      <= 8'h01;
          pow_last_reg <= 8'h01;
          pidx_reg     <= 5'd1;
        end
        POWERS: begin
          pow_last_reg <= pow_p;
          pidx_reg     <= pidx_reg + 5'd1;
        end
        SEARCH: begin
          cur_reg <= cur_p;
          k_reg   <= k_reg + 8'd1;
          if (store_root) count_reg <= count_reg + 5'd1;
          if (k_reg == K_LAST) done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-slot state: term_n advances by pow_n = g^n each step, so term_n = Lambda_n * g^(n*k).
  for (genvar gi = 0; gi < MAX_ERRORS; gi++) begin : g_slot
    logic [GF_W-1:0] term_reg, pow_reg, root_reg, term_p;

    gf_mul8 u_term_mul (.a(term_reg), .b(pow_reg), .reduction_matrix(red_r), .p(term_p));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        term_reg <= '0;
        pow_reg  <= '0;
        root_reg <= '0;
      end else begin
        if (state_reg == CAPTURE)     term_reg <= error_locator[GF_W*gi +: GF_W];
        else if (state_reg == SEARCH) term_reg <= term_p;
        if (state_reg == POWERS && pidx_reg == 5'(gi + 1)) pow_reg <= pow_p;
        if (store_root && count_reg == 5'(gi)) root_reg <= cur_reg;
      end
    end

    assign term_all[gi]               = term_reg;
    assign roots[GF_W*gi +: GF_W]     = root_reg;
  end

  assign done = done_reg;
`ifdef RS_ROOT_COUNT_EN
  assign num_roots = count_reg;
`endif
endmodule

// File: tb/tb_rs_chien_root_search.sv
// Randomised scoreboard bench for rs_chien_root_search.
// The expected root lists come from direct polynomial evaluation over GF(2^8) with P(x)=0x11D.
module tb_rs_chien_root_search;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   generator;
  logic [127:0] error_locator;
  logic [56:0]  reduction_matrix;
  logic         done;
  logic [127:0] roots;
`ifdef RS_ROOT_COUNT_EN
  logic [4:0]   num_roots;
`endif

  typedef struct {
    logic [127:0] roots;
    int           cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  bit   done_seen = 1'b0;

  rs_chien_root_search dut (
    .clk(clk),
    .rst(rst),
    .generator(generator),
    .error_locator(error_locator),
    .reduction_matrix(reduction_matrix),
`ifdef RS_ROOT_COUNT_EN
    .num_roots(num_roots),
`endif
    .done(done),
    .roots(roots)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release; edge 1 is the capture edge.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ s;
      s = xtime(s);
    end
    return r;
  endfunction

  function automatic logic [56:0] red_from_poly();
    logic [56:0] m = '0;
    logic [7:0]  v = 8'h1D;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 8; j++) m[7*j+i] = v[j];
      v = xtime(v);
    end
    return m;
  endfunction

  // Reference: Horner evaluation of Lambda at every g^k, first 16 zeros kept.
  function automatic exp_t model(input logic [7:0] g, input logic [127:0] lam);
    exp_t       e;
    logic [7:0] r = 8'h01;
    logic [7:0] v;
    e.roots = '0;
    e.cnt   = 0;
    for (int k = 0; k < 255; k++) begin
      v = 8'h00;
      for (int n = 16; n >= 1; n--) v = gmul(v, r) ^ lam[8*(n-1) +: 8];
      v = gmul(v, r) ^ 8'h01;
      if (v == 8'h00 && e.cnt < 16) begin
        e.roots[8*e.cnt +: 8] = r;
        e.cnt++;
      end
      r = gmul(r, g);
    end
    return e;
  endfunction

  // Lambda = product of (1 + x_t * X) for random nonzero x_t.
  function automatic logic [127:0] build_lam(input int nroots);
    logic [7:0]   c [17];
    logic [7:0]   x;
    logic [127:0] res = '0;
    c[0] = 8'h01;
    for (int n = 1; n <= 16; n++) c[n] = 8'h00;
    for (int t = 0; t < nroots; t++) begin
      x = 8'($urandom_range(1, 255));
      for (int n = 16; n >= 1; n--) c[n] = c[n] ^ gmul(x, c[n-1]);
    end
    for (int n = 1; n <= 16; n++) res[8*(n-1) +: 8] = c[n];
    return res;
  endfunction

  task automatic do_run(input logic [7:0] g, input logic [127:0] lam, input bit mutate);
    exp_t e;
    generator     = g;
    error_locator = lam;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_roots", roots, 0);
`ifdef RS_ROOT_COUNT_EN
    chk("rst_num_roots", num_roots, 0);
`endif
    e = model(g, lam);
    sb_q.push_back(e);
    rst = 1'b0;
    if (mutate) begin
      @(negedge clk);
      error_locator = {$urandom, $urandom, $urandom, $urandom};
      generator     = 8'($urandom);
    end
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    if (!done) begin
      failures++;
      $display("FAIL done_timeout: got done=0 expected done=1 by edge 272");
      void'(sb_q.pop_back());
    end else begin
      repeat (5) @(negedge clk);
      chk("hold_done", done, 1);
      chk("hold_roots", roots, e.roots);
    end
    $display("run g=%h lam=%h mutate=%0d roots=%h exp_cnt=%0d", g, lam, mutate, roots, e.cnt);
  endtask

  task automatic do_abort();
    generator     = 8'h02;
    error_locator = 128'h0203;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200 && edge_cnt < 100; i++) @(negedge clk);
    chk("pre_abort_roots", roots, 128'h01);
    rst = 1'b1;
    #1;
    chk("abort_done", done, 0);
    chk("abort_roots", roots, 0);
`ifdef RS_ROOT_COUNT_EN
    chk("abort_num_roots", num_roots, 0);
`endif
    $display("abort at edge 100 done=%0d roots=%h", done, roots);
  endtask

  // Monitor: pops the expected result when done rises and compares timing and contents.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        done_seen = 1'b0;
      end else if (done && !done_seen) begin
        done_seen = 1'b1;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: got done with no expected entry, required an entry");
        end else begin
          mon_e = sb_q.pop_front();
          chk("done_edge", edge_cnt, 272);
          chk("roots", roots, mon_e.roots);
`ifdef RS_ROOT_COUNT_EN
          chk("num_roots", num_roots, mon_e.cnt);
`endif
        end
      end
    end
  end

  initial begin
    logic [7:0] g17;
    reduction_matrix = red_from_poly();
    generator        = 8'h02;
    error_locator    = '0;

    do_run(8'h02, 128'h0, 1'b0);
    chk("t1_roots", roots, 128'h0);
    do_run(8'h02, 128'h01, 1'b0);
    chk("t2_roots", roots, 128'h01);
    do_run(8'h02, 128'h02, 1'b0);
    chk("t3_roots", roots, 128'h8E);
    do_run(8'h02, 128'h0203, 1'b0);
    chk("t4_roots", roots, 128'h8E01);
`ifdef RS_ROOT_COUNT_EN
    chk("t4_num_roots", num_roots, 2);
`endif
    do_abort();
    do_run(8'h02, 128'h0203, 1'b0);
    chk("t5_roots", roots, 128'h8E01);
    do_run(8'h02, build_lam(4), 1'b1);
    do_run(8'h01, 128'h01, 1'b0);
    chk("sat_roots", roots, {16{8'h01}});
    g17 = 8'h01;
    for (int i = 0; i < 17; i++) g17 = gmul(g17, 8'h02);
    do_run(g17, build_lam(3), 1'b0);
    do_run(8'h02, build_lam(16), 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_run((i % 3 == 0) ? 8'($urandom_range(1, 255)) : 8'h02,
             build_lam($urandom_range(0, 16)), 1'(i % 2));
    end
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
